mem_port_arb: RTL and testbench

Two-requester arbiter and pipeline sequencer for the BRAM data port (port B). It shares the single data port between the CPU load/store unit (requester 0) and the UART program loader (requester 1). Its registered command stage drives the memory enable, byte write-enable, address and write data. It returns read data to the requester that owns each access, matching the memory's one-cycle synchronous read latency.

---
 rtl/mem_port_arb.sv | 92 +++++++++
 tb/tb_mem_port_arb.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// mem_port_arb: two-requester arbiter and pipeline sequencer for the BRAM data port
// Ports:
//   clk_i, rst_ni                    clock, synchronous active-low reset
//   req*_i/we*_i/addr*_i/wdata*_i    requester 0 (CPU) and 1 (loader) commands
//   gnt*_o                           combinational accept, one per cycle at most
//   rvalid*_o/rdata*_o               response on the owner's port, two cycles after grant
//   mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o  registered memory command
//   mem_rdata_i                      memory read data, one cycle after mem_en_o
// Build option: define MEM_PORT_ARB_RR_EN for round-robin conflict resolution;
// otherwise the CPU has fixed priority.
module mem_port_arb #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_i,
  input  logic [3:0]        we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [31:0]       wdata0_i,
  output logic              gnt0_o,
  output logic              rvalid0_o,
  output logic [31:0]       rdata0_o,
  input  logic              req1_i,
  input  logic [3:0]        we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [31:0]       wdata1_i,
  output logic              gnt1_o,
  output logic              rvalid1_o,
  output logic [31:0]       rdata1_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);
  logic              prio0;
  logic              en_q, en_d;
  logic [3:0]        we_q, we_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              own1_q, own1_d;
  logic              v2_q, own2_q;
  logic              unused_lsb;
  assign unused_lsb = ^{addr0_i[1:0], addr1_i[1:0]};
`ifdef MEM_PORT_ARB_RR_EN
  // last_q=1 means the loader was granted most recently, so the CPU wins the next tie
  logic last_q, last_d;
  assign prio0 = last_q;
  always_comb last_d = gnt0_o ? 1'b0 : gnt1_o ? 1'b1 : last_q;
  always_ff @(posedge clk_i)
    if (!rst_ni) last_q <= 1'b1;
    else         last_q <= last_d;
`else
  assign prio0 = 1'b1;
`endif
  assign gnt0_o = rst_ni & req0_i & (~req1_i | prio0);
  assign gnt1_o = rst_ni & req1_i & ~gnt0_o;
  always_comb begin
    en_d    = gnt0_o | gnt1_o;
    we_d    = gnt0_o ? we0_i : gnt1_o ? we1_i : 4'b0000;
    addr_d  = gnt0_o ? addr0_i[ADDR_W-1:2] : gnt1_o ? addr1_i[ADDR_W-1:2] : addr_q;
    wdata_d = gnt0_o ? wdata0_i : gnt1_o ? wdata1_i : wdata_q;
    own1_d  = gnt1_o ? 1'b1 : gnt0_o ? 1'b0 : own1_q;
  end
  // command stage (en/own1) feeds data stage (v2/own2), matching the read latency
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      en_q    <= 1'b0;
      we_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      own1_q  <= 1'b0;
      v2_q    <= 1'b0;
      own2_q  <= 1'b0;
    end else begin
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      own1_q  <= own1_d;
      v2_q    <= en_q;
      own2_q  <= own1_q;
    end
  assign mem_en_o    = en_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rvalid0_o   = v2_q & ~own2_q;
  assign rvalid1_o   = v2_q & own2_q;
  assign rdata0_o    = mem_rdata_i;
  assign rdata1_o    = mem_rdata_i;
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: table-driven directed check of mem_port_arb against a BRAM model
module tb_mem_port_arb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, gnt0, gnt1, rv0, rv1, mem_en;
  logic [3:0]  we0, we1, mem_we;
  logic [31:0] addr0, addr1, wdata0, wdata1, rdata0, rdata1, mem_wdata, mem_rdata;
  logic [29:0] mem_addr;
  logic [31:0] mem [0:1023];
  int          errors = 0;
  int          checks = 0;
  always #5 clk = ~clk;
  mem_port_arb #(.ADDR_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .gnt0_o(gnt0), .rvalid0_o(rv0), .rdata0_o(rdata0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .gnt1_o(gnt1), .rvalid1_o(rv1), .rdata1_o(rdata1),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );
  always @(posedge clk)
    if (mem_en === 1'b1) begin
      mem_rdata <= mem[mem_addr[9:0]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  typedef struct {
    logic        rst, r0, r1, g0, g1, en, v0, v1, chk;
    logic [3:0]  w0, w1, we;
    logic [31:0] a0, a1, rd;
    logic [29:0] ma;
  } vec_t;
  vec_t vec[$];
  function automatic vec_t mk(logic rst, logic r0, logic [3:0] w0, logic [31:0] a0,
                              logic r1, logic [3:0] w1, logic [31:0] a1,
                              logic g0, logic g1, logic en, logic [3:0] we, logic [29:0] ma,
                              logic v0, logic v1, logic [31:0] rd, logic chk);
    vec_t t;
    t.rst = rst; t.r0 = r0; t.w0 = w0; t.a0 = a0; t.r1 = r1; t.w1 = w1; t.a1 = a1;
    t.g0 = g0; t.g1 = g1; t.en = en; t.we = we; t.ma = ma; t.v0 = v0; t.v1 = v1;
    t.rd = rd; t.chk = chk;
    return t;
  endfunction
  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask
`ifdef MEM_PORT_ARB_RR_EN
  localparam logic [29:0] LW = 30'h7;
`else
  localparam logic [29:0] LW = 30'hB;
`endif
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | i;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 4'h0; we1 = 4'h0;
    addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'hDEADBEEF; wdata1 = 32'h5A5A5A5A;
    repeat (2) @(negedge clk);
    // reset held with a pending CPU write, then released
    for (int i = 0; i < 3; i++) vec.push_back(mk(0,1,4'hF,32'h100, 0,0,0, 0,0, 0,0,0, 0,0,0,0));
    vec.push_back(mk(1,1,4'hF,32'h100, 0,0,0, 1,0, 0,4'h0,30'h0,  0,0,0,0));
    vec.push_back(mk(1,1,4'h0,32'h100, 0,0,0, 1,0, 1,4'hF,30'h40, 0,0,0,0));
    vec.push_back(mk(1,0,0,0, 0,0,0,           0,0, 1,4'h0,30'h40, 1,0,0,0));
    vec.push_back(mk(1,0,0,0, 0,0,0,           0,0, 0,4'h0,30'h40, 1,0,32'hDEADBEEF,1));
    // loader byte store
    vec.push_back(mk(1,0,0,0, 1,4'h4,32'h206,  0,1, 0,4'h0,30'h40, 0,0,0,0));
    vec.push_back(mk(1,0,0,0, 0,0,0,           0,0, 1,4'h4,30'h81, 0,0,0,0));
    vec.push_back(mk(1,0,0,0, 0,0,0,           0,0, 0,4'h0,30'h81, 0,1,0,0));
    // back-to-back CPU reads of words 0,1,2
    vec.push_back(mk(1,1,0,32'h0, 0,0,0,       1,0, 0,0,30'h81, 0,0,0,0));
    vec.push_back(mk(1,1,0,32'h4, 0,0,0,       1,0, 1,0,30'h0,  0,0,0,0));
    vec.push_back(mk(1,1,0,32'h8, 0,0,0,       1,0, 1,0,30'h1,  1,0,32'hC0DE0000,1));
    vec.push_back(mk(1,0,0,0, 0,0,0,           0,0, 1,0,30'h2,  1,0,32'hC0DE0001,1));
    vec.push_back(mk(1,0,0,0, 0,0,0,           0,0, 0,0,30'h2,  1,0,32'hC0DE0002,1));
    vec.push_back(mk(1,0,0,0, 0,0,0,           0,0, 0,0,30'h2,  0,0,0,0));
    // contention, four requests each
`ifdef MEM_PORT_ARB_RR_EN
    vec.push_back(mk(1,1,0,32'h10, 1,0,32'h20, 0,1, 0,0,30'h2, 0,0,0,0));
    vec.push_back(mk(1,1,0,32'h10, 1,0,32'h24, 1,0, 1,0,30'h8, 0,0,0,0));
    vec.push_back(mk(1,1,0,32'h14, 1,0,32'h24, 0,1, 1,0,30'h4, 0,1,32'hC0DE0008,1));
    vec.push_back(mk(1,1,0,32'h14, 1,0,32'h28, 1,0, 1,0,30'h9, 1,0,32'hC0DE0004,1));
    vec.push_back(mk(1,1,0,32'h18, 1,0,32'h28, 0,1, 1,0,30'h5, 0,1,32'hC0DE0009,1));
    vec.push_back(mk(1,1,0,32'h18, 1,0,32'h2C, 1,0, 1,0,30'hA, 1,0,32'hC0DE0005,1));
    vec.push_back(mk(1,1,0,32'h1C, 1,0,32'h2C, 0,1, 1,0,30'h6, 0,1,32'hC0DE000A,1));
    vec.push_back(mk(1,1,0,32'h1C, 0,0,0,      1,0, 1,0,30'hB, 1,0,32'hC0DE0006,1));
    vec.push_back(mk(1,0,0,0, 0,0,0,           0,0, 1,0,30'h7, 0,1,32'hC0DE000B,1));
    vec.push_back(mk(1,0,0,0, 0,0,0,           0,0, 0,0,30'h7, 1,0,32'hC0DE0007,1));
`else
    vec.push_back(mk(1,1,0,32'h10, 1,0,32'h20, 1,0, 0,0,30'h2, 0,0,0,0));
    vec.push_back(mk(1,1,0,32'h14, 1,0,32'h20, 1,0, 1,0,30'h4, 0,0,0,0));
    vec.push_back(mk(1,1,0,32'h18, 1,0,32'h20, 1,0, 1,0,30'h5, 1,0,32'hC0DE0004,1));
    vec.push_back(mk(1,1,0,32'h1C, 1,0,32'h20, 1,0, 1,0,30'h6, 1,0,32'hC0DE0005,1));
    vec.push_back(mk(1,0,0,0, 1,0,32'h20,      0,1, 1,0,30'h7, 1,0,32'hC0DE0006,1));
    vec.push_back(mk(1,0,0,0, 1,0,32'h24,      0,1, 1,0,30'h8, 1,0,32'hC0DE0007,1));
    vec.push_back(mk(1,0,0,0, 1,0,32'h28,      0,1, 1,0,30'h9, 0,1,32'hC0DE0008,1));
    vec.push_back(mk(1,0,0,0, 1,0,32'h2C,      0,1, 1,0,30'hA, 0,1,32'hC0DE0009,1));
    vec.push_back(mk(1,0,0,0, 0,0,0,           0,0, 1,0,30'hB, 0,1,32'hC0DE000A,1));
    vec.push_back(mk(1,0,0,0, 0,0,0,           0,0, 0,0,30'hB, 0,1,32'hC0DE000B,1));
`endif
    vec.push_back(mk(1,0,0,0, 0,0,0,           0,0, 0,0,LW,    0,0,0,0));
    // reset the cycle after a read grant drops its response
    vec.push_back(mk(1,1,0,32'h0, 0,0,0,       1,0, 0,0,LW,    0,0,0,0));
    vec.push_back(mk(0,0,0,0, 0,0,0,           0,0, 1,0,30'h0, 0,0,0,0));
    vec.push_back(mk(1,0,0,0, 0,0,0,           0,0, 0,0,30'h0, 0,0,0,0));
    vec.push_back(mk(1,0,0,0, 0,0,0,           0,0, 0,0,30'h0, 0,0,0,0));
    // first tie after reset goes to the CPU
    vec.push_back(mk(1,1,0,32'h0, 1,0,32'h4,   1,0, 0,0,30'h0, 0,0,0,0));
    vec.push_back(mk(1,0,0,0, 1,0,32'h4,       0,1, 1,0,30'h0, 0,0,0,0));
    vec.push_back(mk(1,0,0,0, 0,0,0,           0,0, 1,0,30'h1, 1,0,32'hC0DE0000,1));
    vec.push_back(mk(1,0,0,0, 0,0,0,           0,0, 0,0,30'h1, 0,1,32'hC0DE0001,1));
    vec.push_back(mk(1,0,0,0, 0,0,0,           0,0, 0,0,30'h1, 0,0,0,0));
    foreach (vec[i]) begin
      @(negedge clk);
      rst_n = vec[i].rst; req0 = vec[i].r0; we0 = vec[i].w0; addr0 = vec[i].a0;
      req1 = vec[i].r1; we1 = vec[i].w1; addr1 = vec[i].a1;
      #1;
      check("gnt0", i, {31'h0, gnt0}, {31'h0, vec[i].g0});
      check("gnt1", i, {31'h0, gnt1}, {31'h0, vec[i].g1});
      check("mem_en", i, {31'h0, mem_en}, {31'h0, vec[i].en});
      check("mem_we", i, {28'h0, mem_we}, {28'h0, vec[i].we});
      check("mem_addr", i, {2'b0, mem_addr}, {2'b0, vec[i].ma});
      check("rvalid0", i, {31'h0, rv0}, {31'h0, vec[i].v0});
      check("rvalid1", i, {31'h0, rv1}, {31'h0, vec[i].v1});
      if (vec[i].we == 4'hF) check("mem_wdata", i, mem_wdata, 32'hDEADBEEF);
      if (vec[i].we == 4'h4) check("mem_wdata", i, mem_wdata, 32'h5A5A5A5A);
      if (vec[i].chk) check("rdata", i, vec[i].v0 ? rdata0 : rdata1, vec[i].rd);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
